// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV64 multicycle controller: FSM states, opcodes,
// ALU-op classes, and every datapath select/control value.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    JAL,
    ILLEGAL
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_SB = 2'b10;
  localparam logic [1:0] IMM_UJ = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // R/I-type operations the ALU implements: add/sub, slt, or, and.
  function automatic logic alu_funct3_legal(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the ALU-op class from the FSM plus instruction fields
// onto the 3-bit alucontrol code.
module aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        op5_i,
  output logic [2:0]  alucontrol_o
);

  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only means sub for register-register ops (op[5]=1).
          3'b000:  alucontrol_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the RV64 multicycle datapath.
// Optional macro MC_CTRL_BNE_EN adds bne support alongside beq.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   branch_f3_ok;
  logic   branch_taken;
  logic   irwrite_s, pcwrite_s, regwrite_s, memwrite_s;

`ifdef MC_CTRL_BNE_EN
  assign branch_f3_ok = (funct3[2:1] == 2'b00);
  assign branch_taken = zero ^ funct3[0];
`else
  assign branch_f3_ok = (funct3 == 3'b000);
  assign branch_taken = zero;
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments to avoid read/write races between blocks.
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:  state_d = alu_funct3_legal(funct3) ? EXECUTER : ILLEGAL;
          OP_ITYPE:  state_d = alu_funct3_legal(funct3) ? EXECUTEI : ILLEGAL;
          OP_BRANCH: state_d = branch_f3_ok ? BRANCH : ILLEGAL;
          OP_JAL:    state_d = JAL;
          default:   state_d = ILLEGAL;
        endcase
      end
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    resultsrc  = RES_ALUOUT;
    adrsrc     = ADR_PC;
    aluop      = ALUOP_ADD;
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      MEMREAD:  adrsrc = ADR_RESULT;
      MEMWB: begin
        resultsrc  = RES_DATA;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        adrsrc     = ADR_RESULT;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB:    regwrite_s = 1'b1;
      BRANCH: begin
        alusrca   = SRCA_RS1;
        aluop     = ALUOP_SUB;
        pcwrite_s = branch_taken;
      end
      JAL: begin
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        pcwrite_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing is written while reset is held.
  assign irwrite  = irwrite_s  & reset;
  assign pcwrite  = pcwrite_s  & reset;
  assign regwrite = regwrite_s & reset;
  assign memwrite = memwrite_s & reset;
  assign illegal  = (state_q == ILLEGAL);

  always_comb begin
    case (op)
      OP_LOAD, OP_ITYPE: immsrc = IMM_I;
      OP_STORE:          immsrc = IMM_S;
      OP_BRANCH:         immsrc = IMM_SB;
      OP_JAL:            immsrc = IMM_UJ;
      default:           immsrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .aluop_i      (aluop),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: each row names the expected
// state, a reference model turns it into expected outputs via a scoreboard queue.
module tb_multicycle_controller;

  typedef enum logic [3:0] {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECUTER, T_EXECUTEI, T_ALUWB, T_BRANCH, T_JAL, T_ILLEGAL
  } tst_e;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       zero;
    logic       mr;
    tst_e       st;
  } vec_t;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, illegal;
  logic [16:0] act;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .immsrc(immsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .resultsrc(resultsrc), .adrsrc(adrsrc),
    .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite), .illegal(illegal)
  );

  assign act = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                irwrite, pcwrite, regwrite, memwrite, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] alu_funct(input vec_t v);
    case (v.f3)
      3'b000:  return (v.f7b5 && v.op[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs written directly from the state/output table.
  function automatic logic [16:0] model(input vec_t v);
    logic [1:0] imm, a, b, res;
    logic       adr, irw, pcw, rw, mw, ill;
    logic [2:0] alu;
    {a, b, res, adr, alu, irw, pcw, rw, mw, ill} = '0;
    case (v.op)
      LD, IT:  imm = 2'b00;
      ST:      imm = 2'b01;
      BR:      imm = 2'b10;
      JL:      imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (v.st)
      T_FETCH:    begin b = 2'b10; res = 2'b10; irw = v.mr; pcw = v.mr; end
      T_DECODE:   begin a = 2'b01; b = 2'b01; end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; end
      T_MEMREAD:  adr = 1'b1;
      T_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      T_EXECUTER: begin a = 2'b10; alu = alu_funct(v); end
      T_EXECUTEI: begin a = 2'b10; b = 2'b01; alu = alu_funct(v); end
      T_ALUWB:    rw = 1'b1;
      T_BRANCH: begin
        a = 2'b10; alu = 3'b001;
`ifdef MC_CTRL_BNE_EN
        pcw = v.zero ^ v.f3[0];
`else
        pcw = v.zero;
`endif
      end
      T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      T_ILLEGAL:  ill = 1'b1;
      default: ;
    endcase
    if (!v.rst_n) {irw, pcw, rw, mw} = 4'b0000;
    return {imm, a, b, res, adr, alu, irw, pcw, rw, mw, ill};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (imm,a,b,res,adr,alu,ir,pc,rw,mw,ill)",
               name, got, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    reset     = v.rst_n;
    op        = v.op;
    funct3    = v.f3;
    funct7b5  = v.f7b5;
    zero      = v.zero;
    mem_ready = v.mr;
    exp_q.push_back(model(v));
    #1;
    check($sformatf("%s %s", tag, v.st.name()), act, exp_q.pop_front());
  endtask

  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f,
                              input logic f7, input logic z, input logic m, input tst_e s);
    vec_t v;
    v.rst_n = r; v.op = o; v.f3 = f; v.f7b5 = f7; v.zero = z; v.mr = m; v.st = s;
    return v;
  endfunction

  function automatic void add(input logic [6:0] o, input logic [2:0] f, input logic f7,
                              input logic z, input logic m, input tst_e s);
    vecs.push_back(mk(1'b1, o, f, f7, z, m, s));
  endfunction

  // R/I-type: four states; mr drives the non-FETCH states to show it is ignored there.
  function automatic void alu_instr(input logic [6:0] o, input logic [2:0] f,
                                    input logic f7, input logic m);
    add(o, f, f7, 1'b1, 1'b1, T_FETCH);
    add(o, f, f7, 1'b1, m, T_DECODE);
    add(o, f, f7, 1'b1, m, (o == RT) ? T_EXECUTER : T_EXECUTEI);
    add(o, f, f7, 1'b0, m, T_ALUWB);
  endfunction

  task automatic illegal_seq(input logic [6:0] o, input logic [2:0] f, input string tag);
    step(mk(1'b1, o, f, 1'b0, 1'b0, 1'b1, T_FETCH), tag);
    step(mk(1'b1, o, f, 1'b0, 1'b0, 1'b1, T_DECODE), tag);
    for (int i = 0; i < 11; i++)
      step(mk(1'b1, o, f, 1'b1, i[1], i[0], T_ILLEGAL), $sformatf("%s hold%0d", tag, i));
    step(mk(1'b0, o, f, 1'b0, 1'b0, 1'b1, T_FETCH), {tag, " reset"});
    step(mk(1'b1, o, f, 1'b0, 1'b0, 1'b0, T_FETCH), {tag, " release"});
  endtask

  initial begin
    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    step(mk(1'b0, RT, 3'b000, 1'b0, 1'b0, 1'b1, T_FETCH), "in reset");
    step(mk(1'b0, ST, 3'b011, 1'b0, 1'b1, 1'b1, T_FETCH), "in reset");

    alu_instr(RT, 3'b000, 1'b0, 1'b0);   // add
    alu_instr(RT, 3'b000, 1'b1, 1'b1);   // sub
    alu_instr(IT, 3'b000, 1'b1, 1'b0);   // addi with bit30 set stays add
    alu_instr(IT, 3'b010, 1'b0, 1'b1);   // slti
    alu_instr(RT, 3'b110, 1'b0, 1'b0);   // or
    alu_instr(IT, 3'b111, 1'b1, 1'b1);   // andi
    alu_instr(RT, 3'b111, 1'b0, 1'b0);   // and
    add(LD, 3'b011, 1'b0, 1'b0, 1'b0, T_FETCH);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b1, T_FETCH);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b1, T_DECODE);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMADR);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMREAD);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b1, T_MEMREAD);
    add(LD, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMWB);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b1, T_FETCH);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b0, T_DECODE);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b1, T_MEMADR);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMWRITE);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMWRITE);
    add(ST, 3'b011, 1'b0, 1'b0, 1'b1, T_MEMWRITE);
    add(BR, 3'b000, 1'b0, 1'b1, 1'b1, T_FETCH);
    add(BR, 3'b000, 1'b0, 1'b1, 1'b1, T_DECODE);
    add(BR, 3'b000, 1'b0, 1'b1, 1'b1, T_BRANCH);
    add(BR, 3'b000, 1'b0, 1'b0, 1'b1, T_FETCH);
    add(BR, 3'b000, 1'b0, 1'b0, 1'b1, T_DECODE);
    add(BR, 3'b000, 1'b0, 1'b0, 1'b1, T_BRANCH);
    add(JL, 3'b000, 1'b0, 1'b0, 1'b1, T_FETCH);
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, T_DECODE);
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, T_JAL);
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, T_ALUWB);
    add(RT, 3'b000, 1'b0, 1'b0, 1'b0, T_FETCH);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of a stalled store.
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_FETCH), "rstmid");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_DECODE), "rstmid");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMADR), "rstmid");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b0, T_MEMWRITE), "rstmid");
    #1 reset = 1'b0;
    exp_q.push_back(model(mk(1'b0, ST, 3'b011, 1'b0, 1'b0, 1'b0, T_FETCH)));
    #1 check("rstmid memwrite drop", act, exp_q.pop_front());
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b0, T_FETCH), "rstmid after");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_FETCH), "rstmid after");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_DECODE), "rstmid after");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_MEMADR), "rstmid after");
    step(mk(1'b1, ST, 3'b011, 1'b0, 1'b0, 1'b1, T_MEMWRITE), "rstmid after");
    step(mk(1'b1, RT, 3'b000, 1'b0, 1'b0, 1'b0, T_FETCH), "rstmid after");

    illegal_seq(7'b1111111, 3'b000, "badop");
    illegal_seq(RT, 3'b001, "rtype f3=001");
    illegal_seq(BR, 3'b100, "blt");
`ifdef MC_CTRL_BNE_EN
    step(mk(1'b1, BR, 3'b001, 1'b0, 1'b0, 1'b1, T_FETCH), "bne");
    step(mk(1'b1, BR, 3'b001, 1'b0, 1'b0, 1'b1, T_DECODE), "bne");
    step(mk(1'b1, BR, 3'b001, 1'b0, 1'b0, 1'b1, T_BRANCH), "bne");
    step(mk(1'b1, BR, 3'b001, 1'b0, 1'b1, 1'b0, T_FETCH), "bne");
`else
    illegal_seq(BR, 3'b001, "bne");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the RV64 multicycle processor. Decodes the latched instruction fields, steps a Moore state machine through fetch/decode/execute/memory/writeback, and drives every datapath select and write enable. This includes the 2-bit `immsrc` consumed by the immediate extender. Memory accesses use a `mem_ready` handshake so slow instruction/data memory can insert wait states.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `immsrc`  out  2  00 I-type, 01 S-type, 10 SB-type, 11 UJ-type.
- `alusrca`  out  2  00 PC, 01 OldPC, 10 rs1 register.
- `alusrcb`  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
- `resultsrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc`  out  1  0 PC, 1 Result.
- `alucontrol`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite`  out  1 each  write enables.
- `illegal`  out  1  sticky flag for an undecodable instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ILLEGAL.
- **FETCH:**
  - Outputs: adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10.
  - irwrite and pcwrite equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE:** alusrca=01, alusrcb=01, add, so the branch/jump target lands in ALUOut. Next state by `op`:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → ILLEGAL
  - An R/I type with funct3 not in {000, 010, 110, 111} also → ILLEGAL.
- **MEMADR:** alusrca=10, alusrcb=01, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD:** adrsrc=1, resultsrc=00. Waits on `mem_ready`, then → MEMWB.
- **MEMWB:** resultsrc=01, regwrite=1, then → FETCH.
- **MEMWRITE:** adrsrc=1, resultsrc=00, memwrite=1. memwrite is held asserted until `mem_ready`=1, then → FETCH.
- **EXECUTER / EXECUTEI:** alusrca=10, alusrcb=00 or 01 respectively, ALU-op class "funct". Next → ALUWB.
- **ALUWB:** resultsrc=00, regwrite=1, then → FETCH.
- **BRANCH:** alusrca=10, alusrcb=00, sub, resultsrc=00, pcwrite=`zero`. Next → FETCH.
- **JAL:** alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1. Next → ALUWB, which writes PC+4 into rd.
- **ILLEGAL:** all enables 0, `illegal`=1. Terminal until reset.
- **ALU decode for class "funct"** (by funct3):
  - 000: sub when (funct7b5 & op[5]), otherwise add.
  - 010: slt.
  - 110: or.
  - 111: and.
- **immsrc** is combinational from `op` in every state:
  - 0000011, 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - anything else → 00
- Selects not listed for a state are 00/0.

## Timing
- Moore outputs: decoded from the state register only, except `zero`→pcwrite in BRANCH and `mem_ready`→irwrite/pcwrite in FETCH.
- Reset assertion:
  - state=FETCH and `illegal`=0 immediately (asynchronous).
  - All four write enables forced to 0 combinationally while `reset`=0.
  - Selects take their FETCH values.
- Instruction latency with `mem_ready` tied high:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- A `mem_ready` pulse in any other state is ignored.
- A mid-instruction reset abandons the instruction with no further write enables.

## Configuration
- `MC_CTRL_BNE_EN`:
  - Defined: BRANCH sets pcwrite = `zero` XOR funct3[0], supporting beq (000) and bne (001). DECODE sends branches with funct3 not in {000, 001} to ILLEGAL.
  - Undefined: only beq is supported. Any branch with funct3≠000 → ILLEGAL.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - immsrc encodings;
  - alucontrol encodings;
  - select encodings.
- Sub-module `aludec`: combinational, takes ALU-op class, funct3, funct7b5 and op[5]; outputs `alucontrol`.
- Top-level contents: state register, next-state logic, output decode, immsrc decode.

## Test plan
- Reset low mid-MEMWRITE: memwrite drops to 0 in the same cycle. After release, state=FETCH and irwrite follows `mem_ready`.
- add (op 0110011, f3 000, f7b5 0), `mem_ready`=1:
  - state sequence FETCH, DECODE, EXECUTER, ALUWB;
  - alucontrol=000 in EXECUTER;
  - regwrite=1 only in cycle 4.
- sd (op 0100011, f3 011) with `mem_ready` low for 2 cycles in MEMWRITE: memwrite high for 3 cycles, immsrc=01, back in FETCH on cycle 7.
- beq with zero=1: pcwrite=1 in BRANCH, alucontrol=001, immsrc=10. Repeat with zero=0: pcwrite=0.
- jal (op 1101111): immsrc=11, pcwrite=1 in JAL, regwrite=1 with resultsrc=00 in the following ALUWB.
- op=1111111: state=ILLEGAL after DECODE, `illegal`=1 and all enables 0 for 10+ cycles until reset. With `MC_CTRL_BNE_EN` undefined, a branch with f3=001 also ends in ILLEGAL.
